jk_register_bank: RTL and testbench
===================================

# jk_register_bank

Parametrised multi-bit JK register bank: WIDTH independent JK flip-flops sharing one clock, with synchronous preset/clear, a clock enable and a built-in synchronous up/down counter mode that drives every bit through JK toggle semantics. Next-generation replacement for single-bit JK storage in control and sequencing logic. Used wherever a group of set/reset/toggle flags or a small wrap-around counter is needed.

## Interface
- WIDTH, 8, number of JK bits (≥1)
- RESET_VALUE, {WIDTH{1'b0}}, value loaded on asynchronous reset
- PRESET_VALUE, {WIDTH{1'b1}}, value loaded by preset_sync
- clock_pos  in  1  rising-edge clock
- reset_pos  in  1  asynchronous, active-high reset
- enable  in  1  clock enable for mode operations
- mode  in  2  operating mode: 00 bitwise JK, 01 count up, 10 count down, 11 hold
- signal_J  in  WIDTH  per-bit J (bitwise mode only)
- signal_K  in  WIDTH  per-bit K (bitwise mode only)
- preset_sync  in  1  synchronous load of PRESET_VALUE
- clear_sync  in  1  synchronous load of all zeros
- change_clear  in  1  clears change_flag
- signal_out  out  WIDTH  register state
- signal_out_neg  out  WIDTH  bitwise inverse of signal_out
- terminal_count  out  1  counter at wrap point
- change_flag  out  1  sticky "state changed" indicator

## Operation
- reset_pos high: signal_out = RESET_VALUE immediately, independent of clock; change_flag = 0.
- Per rising edge, priority: clear_sync > preset_sync > enable low (hold) > mode.
- clear_sync and preset_sync both high: clear wins, state = 0.
- Bitwise mode, per bit i: J=0,K=0 hold; J=0,K=1 → 0; J=1,K=0 → 1; J=1,K=1 toggle.
- Count up: bit i toggles iff bits [i-1:0] all 1 (bit 0 always toggles); all-ones wraps to 0.
- Count down: bit i toggles iff bits [i-1:0] all 0; zero wraps to all-ones.
- Hold mode: no change; signal_J/K ignored outside bitwise mode.
- Arithmetic modulo 2^WIDTH; no saturation.
- terminal_count = enable & ((mode==01 & signal_out all ones) | (mode==10 & signal_out all zeros)); 0 in other modes.
- signal_out_neg always equals ~signal_out, including during reset.

## Timing
- Synchronous operations: state visible on signal_out one cycle after the sampling edge (latency 1).
- terminal_count combinational from current state, mode, enable; asserted in the cycle before wrap.
- Asynchronous reset asserts without clock; release is synchronous (first operation on the first edge after deassertion).
- Reset mid-count: counting restarts from RESET_VALUE; no partial state retained.
- Mode change takes effect on the same edge at which the new mode is sampled.
- change_flag: set at the edge where next state ≠ current state; change_clear clears at the edge; simultaneous set and clear → set wins.

## Configuration
- JK_BANK_CHANGE_FLAG_EN defined: change_flag logic per Timing section compiled in.
- Undefined: change_flag tied to 0, change_clear ignored; ports retained for interface stability, no flag register.

## Structure
- Shared package jk_pkg: mode typedef enum (JK_MODE_BITWISE=2'b00, JK_MODE_COUNT_UP=2'b01, JK_MODE_COUNT_DOWN=2'b10, JK_MODE_HOLD=2'b11) and JK next-state constants.
- Sub-module jk_bit_cell: single-bit next-state function (J, K, current) → next; instantiated WIDTH times via generate; counter modes drive its J=K=toggle-enable.
- Top level holds the state register, priority logic, carry/borrow chains and change flag.

## Test plan
- Assert reset_pos mid-cycle with state 8'hA5 → signal_out = 8'h00 and signal_out_neg = 8'hFF before next edge; change_flag = 0.
- Bitwise mode, state 8'h0F, J=8'hF0, K=8'h3C → next state 8'hF3 (set, clear, toggle, hold all exercised).
- Count up from 8'hFE, enable=1 → 8'hFF with terminal_count=1, then 8'h00 with terminal_count=0; count down from 8'h01 → 8'h00 (terminal_count=1) → 8'hFF.
- clear_sync=1 and preset_sync=1 together with state 8'h55 → 8'h00; preset_sync alone → 8'hFF; enable=0 in count mode → state unchanged.
- With JK_BANK_CHANGE_FLAG_EN: state change sets change_flag; change_clear with no change → 0; change_clear coincident with a change → stays 1. Without macro → change_flag constantly 0.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank: operating-mode encoding
// and the single-bit JK next-state codes used by jk_bit_cell.
package jk_pkg;

  // Operating mode presented on the bank's 2-bit mode port.
  typedef enum logic [1:0] {
    JK_MODE_BITWISE    = 2'b00,
    JK_MODE_COUNT_UP   = 2'b01,
    JK_MODE_COUNT_DOWN = 2'b10,
    JK_MODE_HOLD       = 2'b11
  } jk_mode_e;

  // JK input pair {J,K} codes and the action each one selects.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Reference next-state function for one JK bit.
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic r;
    case ({j, k})
      JK_HOLD:   r = q;
      JK_RESET:  r = 1'b0;
      JK_SET:    r = 1'b1;
      default:   r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_bit_cell.sv
// Single-bit JK next-state cell: (J, K, current) -> next.
// Purely combinational; the bank owns the storage flop.
module jk_bit_cell
  import jk_pkg::*;
(
  input  logic j,
  input  logic k,
  input  logic q,
  output logic q_next
);

  // Decode the JK pair into hold / reset / set / toggle.
  always_comb begin
    q_next = q;
    case ({j, k})
      JK_HOLD:   q_next = q;
      JK_RESET:  q_next = 1'b0;
      JK_SET:    q_next = 1'b1;
      JK_TOGGLE: q_next = ~q;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/jk_register_bank.sv
// WIDTH-bit bank of JK flip-flops with synchronous clear/preset, clock
// enable, and up/down counter modes that drive each bit through its JK
// cell as a toggle (J=K=toggle enable from the carry/borrow chain).
// Optional feature: define JK_BANK_CHANGE_FLAG_EN to build the sticky
// change_flag register; otherwise change_flag is tied low and
// change_clear is ignored (ports kept for interface stability).
module jk_register_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clock_pos,
  input  logic             reset_pos,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] signal_J,
  input  logic [WIDTH-1:0] signal_K,
  input  logic             preset_sync,
  input  logic             clear_sync,
  input  logic             change_clear,
  output logic [WIDTH-1:0] signal_out,
  output logic [WIDTH-1:0] signal_out_neg,
  output logic             terminal_count,
  output logic             change_flag
);

  jk_mode_e         mode_e;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH:0]   carry;      // carry[i]: bits [i-1:0] all ones
  logic [WIDTH:0]   borrow;     // borrow[i]: bits [i-1:0] all zeros
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic [WIDTH-1:0] mode_next;
  logic             all_ones;
  logic             all_zeros;

  assign mode_e = jk_mode_e'(mode);

  // Ripple chains: bit 0 always toggles when counting.
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
      assign carry[gi+1]  = carry[gi]  &  state_q[gi];
      assign borrow[gi+1] = borrow[gi] & ~state_q[gi];
    end
  endgenerate

  assign all_ones  = carry[WIDTH];
  assign all_zeros = borrow[WIDTH];

  // Select what each JK cell sees: external J/K in bitwise mode, the
  // carry/borrow chain as a toggle enable when counting, idle otherwise.
  always_comb begin
    cell_j = '0;
    cell_k = '0;
    case (mode_e)
      JK_MODE_BITWISE: begin
        cell_j = signal_J;
        cell_k = signal_K;
      end
      JK_MODE_COUNT_UP: begin
        cell_j = carry[WIDTH-1:0];
        cell_k = carry[WIDTH-1:0];
      end
      JK_MODE_COUNT_DOWN: begin
        cell_j = borrow[WIDTH-1:0];
        cell_k = borrow[WIDTH-1:0];
      end
      JK_MODE_HOLD: begin
        cell_j = '0;
        cell_k = '0;
      end
      default: begin
        cell_j = '0;
        cell_k = '0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_bit_cell u_cell (
        .j      (cell_j[gi]),
        .k      (cell_k[gi]),
        .q      (state_q[gi]),
        .q_next (mode_next[gi])
      );
    end
  endgenerate

  // Priority: clear beats preset, both beat the enable, enable gates mode.
  always_comb begin
    state_d = state_q;
    if (clear_sync) begin
      state_d = '0;
    end else if (preset_sync) begin
      state_d = PRESET_VALUE;
    end else if (!enable) begin
      state_d = state_q;
    end else begin
      state_d = mode_next;
    end
  end

  // State register; reset loads RESET_VALUE without waiting for a clock.
  always_ff @(posedge clock_pos or posedge reset_pos) begin
    if (reset_pos) begin
      state_q <= RESET_VALUE;
    end else begin
      state_q <= state_d;
    end
  end

  assign signal_out     = state_q;
  assign signal_out_neg = ~state_q;

  // Raised in the cycle before the counter wraps in its current direction.
  assign terminal_count = enable &
                          (((mode_e == JK_MODE_COUNT_UP)   & all_ones) |
                           ((mode_e == JK_MODE_COUNT_DOWN) & all_zeros));

`ifdef JK_BANK_CHANGE_FLAG_EN
  logic change_flag_q;
  logic change_flag_d;

  // A state change at this edge wins over a coincident clear request.
  always_comb begin
    change_flag_d = change_flag_q;
    if (state_d != state_q) begin
      change_flag_d = 1'b1;
    end else if (change_clear) begin
      change_flag_d = 1'b0;
    end
  end

  // Sticky change indicator, cleared by reset.
  always_ff @(posedge clock_pos or posedge reset_pos) begin
    if (reset_pos) begin
      change_flag_q <= 1'b0;
    end else begin
      change_flag_q <= change_flag_d;
    end
  end

  assign change_flag = change_flag_q;
`else
  logic unused_change_clear;
  assign unused_change_clear = change_clear;
  assign change_flag         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_register_bank.sv
// Self-checking bench for jk_register_bank (WIDTH=8, default values).
// Table-driven vectors plus hand sequences for reset and the change flag,
// then constrained-random vectors against a behavioural model.
module tb_jk_register_bank;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [1:0]   mode;
  logic [W-1:0] sig_j;
  logic [W-1:0] sig_k;
  logic         preset_sync;
  logic         clear_sync;
  logic         change_clear;
  logic [W-1:0] signal_out;
  logic [W-1:0] signal_out_neg;
  logic         terminal_count;
  logic         change_flag;

  always #5 clk = ~clk;

  jk_register_bank #(.WIDTH(W)) dut (
    .clock_pos      (clk),
    .reset_pos      (rst),
    .enable         (enable),
    .mode           (mode),
    .signal_J       (sig_j),
    .signal_K       (sig_k),
    .preset_sync    (preset_sync),
    .clear_sync     (clear_sync),
    .change_clear   (change_clear),
    .signal_out     (signal_out),
    .signal_out_neg (signal_out_neg),
    .terminal_count (terminal_count),
    .change_flag    (change_flag)
  );

  typedef struct {
    logic         clr;
    logic         pre;
    logic         en;
    logic [1:0]   md;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] exp_q;
    logic         exp_tc;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         flag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  logic [W-1:0] model_q;
  logic         model_flag;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: counting done with plain arithmetic.
  function automatic logic [W-1:0] ref_next(input logic clr, input logic pre, input logic en,
                                            input logic [1:0] md, input logic [W-1:0] j,
                                            input logic [W-1:0] k, input logic [W-1:0] q);
    if (clr) return '0;
    if (pre) return '1;
    if (!en) return q;
    case (md)
      2'b00:   return (j & ~q) | (~k & q);
      2'b01:   return q + 1'b1;
      2'b10:   return q - 1'b1;
      default: return q;
    endcase
  endfunction

  function automatic logic ref_tc(input logic en, input logic [1:0] md, input logic [W-1:0] q);
    return en && ((md == 2'b01 && q == '1) || (md == 2'b10 && q == '0));
  endfunction

  // One transaction: drive at negedge, check terminal_count, push the
  // expected state, then pop and compare just after the rising edge.
  task automatic apply(input logic clr, input logic pre, input logic en, input logic [1:0] md,
                       input logic [W-1:0] j, input logic [W-1:0] k, input logic cc,
                       input logic [W-1:0] exp_q, input logic exp_tc, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    clear_sync   = clr;
    preset_sync  = pre;
    enable       = en;
    mode         = md;
    sig_j        = j;
    sig_k        = k;
    change_clear = cc;
    #1;
    check({tag, " terminal_count"}, W'(terminal_count), W'(exp_tc));
    e.q = exp_q;
`ifdef JK_BANK_CHANGE_FLAG_EN
    e.flag = (exp_q != model_q) | (model_flag & ~cc);
`else
    e.flag = 1'b0;
`endif
    sb.push_back(e);
    model_q    = exp_q;
    model_flag = e.flag;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s scoreboard: got empty queue, expected one entry", tag);
    end else begin
      got = sb.pop_front();
      check({tag, " signal_out"}, signal_out, got.q);
      check({tag, " signal_out_neg"}, signal_out_neg, ~got.q);
      check({tag, " change_flag"}, W'(change_flag), W'(got.flag));
    end
    $display("%s: clr=%b pre=%b en=%b mode=%b J=%h K=%h cc=%b -> out=%h tc_before=%b flag=%b",
             tag, clr, pre, en, md, j, k, cc, signal_out, exp_tc, change_flag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'b00; sig_j = '0; sig_k = '0;
    preset_sync = 1'b0; clear_sync = 1'b0; change_clear = 1'b0;
    model_q = '0; model_flag = 1'b0;

    // clr pre en mode J K -> expected state, terminal_count before edge
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'hFF, 1'b0}); // preset
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 8'h55, 8'hAA, 8'h55, 1'b0}); // load 55
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b0}); // clear beats preset
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 8'h0F, 8'hF0, 8'h0F, 1'b0}); // load 0F
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 8'hF0, 8'h3C, 8'hF3, 1'b0}); // set/clr/tgl/hold
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b11, 8'hFF, 8'hFF, 8'hF3, 1'b0}); // hold mode
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 8'h00, 8'hF3, 1'b0}); // enable low
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 8'hFE, 8'h01, 8'hFE, 1'b0}); // load FE
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'hFF, 1'b0}); // up FE->FF
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b1}); // up wrap
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'h01, 1'b0}); // up 00->01
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'h00, 1'b0}); // down 01->00
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'hFF, 1'b1}); // down wrap
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'b10, 8'h00, 8'h00, 8'hFF, 1'b0}); // enable low, no tc
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 8'hFF, 1'b0}); // bitwise at FF, no tc
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'h00, 1'b1}); // up wrap again
    vecs.push_back('{1'b0, 1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 1'b0}); // hold at 00, no tc
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'b10, 8'h00, 8'h00, 8'hFF, 1'b1}); // preset over count

    repeat (2) @(posedge clk);
    #1;
    check("reset signal_out", signal_out, 8'h00);
    check("reset signal_out_neg", signal_out_neg, 8'hFF);
    check("reset change_flag", W'(change_flag), 8'h00);
    $display("reset: out=%h neg=%h flag=%b", signal_out, signal_out_neg, change_flag);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].clr, vecs[i].pre, vecs[i].en, vecs[i].md, vecs[i].j, vecs[i].k, 1'b0,
            vecs[i].exp_q, vecs[i].exp_tc, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in mid-cycle with state A5.
    apply(1'b0, 1'b0, 1'b1, 2'b00, 8'hA5, 8'h5A, 1'b0, 8'hA5, 1'b0, "load_a5");
    #3;
    rst  = 1'b1;
    mode = 2'b01;
    #1;
    check("async reset signal_out", signal_out, 8'h00);
    check("async reset signal_out_neg", signal_out_neg, 8'hFF);
    check("async reset change_flag", W'(change_flag), 8'h00);
    $display("async_reset: out=%h neg=%h flag=%b", signal_out, signal_out_neg, change_flag);
    @(posedge clk);
    #1;
    check("reset held over edge", signal_out, 8'h00);
    $display("reset_held: out=%h", signal_out);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first count after release", signal_out, 8'h01);
    $display("release_count: out=%h", signal_out);
    model_q = 8'h01;
`ifdef JK_BANK_CHANGE_FLAG_EN
    model_flag = 1'b1;
`else
    model_flag = 1'b0;
`endif

    // Change-flag sequence: set, clear with no change, clear coincident with change.
    apply(1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 1'b0, 8'h02, 1'b0, "flag_set");
    apply(1'b0, 1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 1'b1, 8'h02, 1'b0, "flag_clear");
    apply(1'b0, 1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 1'b0, 8'h02, 1'b0, "flag_stay_clear");
    apply(1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 1'b1, 8'h03, 1'b0, "flag_set_wins");
    apply(1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 8'h00, 1'b0, 8'h03, 1'b0, "flag_sticky");

    // Constrained-random vectors against the behavioural model.
    for (int i = 0; i < 150; i++) begin
      logic         r_clr;
      logic         r_pre;
      logic         r_en;
      logic         r_cc;
      logic [1:0]   r_md;
      logic [W-1:0] r_j;
      logic [W-1:0] r_k;
      r_clr = ($urandom_range(0, 15) == 0);
      r_pre = ($urandom_range(0, 15) == 0);
      r_en  = ($urandom_range(0, 5) != 0);
      r_cc  = ($urandom_range(0, 3) == 0);
      r_md  = 2'($urandom_range(0, 3));
      r_j   = 8'($urandom());
      r_k   = 8'($urandom());
      apply(r_clr, r_pre, r_en, r_md, r_j, r_k, r_cc,
            ref_next(r_clr, r_pre, r_en, r_md, r_j, r_k, model_q),
            ref_tc(r_en, r_md, model_q), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
